// File: rtl/wave_fifo_mcu_reader_if.sv
// Bus bundle between the capture-FIFO reader, its show-ahead FIFO and the
// MCU parallel read port. The reader block takes the slave view; the
// surrounding logic (FIFO, writer, MCU pins) takes the master view.
interface wave_fifo_mcu_reader_if;
    logic        save_dat_to_fifo_flag;
    logic [11:0] fifo_q;
    logic        fifo_empty;
    logic [12:0] fifo_usedw;
    logic        fifo_rdreq;
    logic        fifo_idle;
    logic        irq_out;
    logic        mcu_cs_n;
    logic        mcu_rd_n;
    logic [1:0]  mcu_addr;
    logic [15:0] mcu_rdata;

    modport slave (
        input  save_dat_to_fifo_flag, fifo_q, fifo_empty, fifo_usedw,
        input  mcu_cs_n, mcu_rd_n, mcu_addr,
        output fifo_rdreq, fifo_idle, irq_out, mcu_rdata
    );

    modport master (
        output save_dat_to_fifo_flag, fifo_q, fifo_empty, fifo_usedw,
        output mcu_cs_n, mcu_rd_n, mcu_addr,
        input  fifo_rdreq, fifo_idle, irq_out, mcu_rdata
    );
endinterface

// File: rtl/wave_fifo_mcu_reader.sv
// Drains one captured waveform frame from a show-ahead FIFO to the MCU over
// an asynchronous parallel read bus, with frame interrupt and timeout flush.
module wave_fifo_mcu_reader #(
    parameter int          FRAME_WORDS      = 4096,
    parameter int          IRQ_PULSE_CYCLES = 100,
    parameter int          TIMEOUT_SEC      = 10,
    parameter logic [15:0] BLOCK_ID         = 16'h9238
) (
    input  logic clk_100m,
    input  logic reset_n,
    input  logic one_second_clk,
    wave_fifo_mcu_reader_if.slave bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_MCU = 3'd1;
    localparam logic [2:0] ST_READING  = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_FLUSH    = 3'd4;

    localparam int TMO_W = $clog2(TIMEOUT_SEC + 1);
    localparam int IRQ_W = $clog2(IRQ_PULSE_CYCLES + 1);
    localparam logic [12:0]      FRAME_END = 13'(FRAME_WORDS);
    localparam logic [12:0]      LAST_IDX  = 13'(FRAME_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_SEC);
    localparam logic [IRQ_W-1:0] IRQ_LOAD  = IRQ_W'(IRQ_PULSE_CYCLES - 1);
    // Idle levels of {one_second_clk, mcu_rd_n, mcu_cs_n}
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    logic [2:0]       meta_reg, sync_reg;
    logic             rd_d_reg, sec_d_reg;
    logic [2:0]       state_reg, state_next;
    logic [12:0]      words_read_reg;
    logic [15:0]      frame_cnt_reg;
    logic [TMO_W-1:0] timeout_cnt_reg;
    logic [IRQ_W-1:0] irq_cnt_reg;
    logic             irq_reg;
    logic             underflow_reg, flushed_reg, clr_pend_reg;
    logic [15:0]      rdata_reg, rdata_next;

    logic cs_s, rd_s, sec_s;
    logic read_evt, sec_rise, in_frame, timeout_hit, words_left;
    logic data_rd, data_avail, pop_data, pop_flush, frame_ready, last;

    assign cs_s  = sync_reg[0];
    assign rd_s  = sync_reg[1];
    assign sec_s = sync_reg[2];

    assign read_evt    = !rd_s && rd_d_reg && !cs_s;
    assign sec_rise    = sec_s && !sec_d_reg;
    assign in_frame    = (state_reg == ST_WAIT_MCU) || (state_reg == ST_READING);
    assign frame_ready = in_frame;
    assign timeout_hit = in_frame && (timeout_cnt_reg == TMO_LIMIT);
    assign words_left  = (words_read_reg != FRAME_END);
    assign last        = (words_read_reg == LAST_IDX);
    assign data_rd     = read_evt && (bus.mcu_addr == 2'd1);
    // Data is only served from the FIFO while a frame is open; a read that
    // collides with the timeout still sees the head word but does not pop.
    assign data_avail  = in_frame && words_left && !bus.fifo_empty;
    assign pop_data    = data_rd && data_avail && !timeout_hit;
    assign pop_flush   = (state_reg == ST_FLUSH) && !bus.fifo_empty;

    assign bus.fifo_rdreq = pop_data || pop_flush;
    assign bus.fifo_idle  = reset_n && (state_reg == ST_IDLE) && bus.fifo_empty;
    assign bus.irq_out    = irq_reg;
    assign bus.mcu_rdata  = rdata_reg;

    // Two-flop synchronizers plus edge-detect history for the async inputs
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg  <= SYNC_IDLE;
            sync_reg  <= SYNC_IDLE;
            rd_d_reg  <= 1'b1;
            sec_d_reg <= 1'b0;
        end else begin
            meta_reg  <= {one_second_clk, bus.mcu_rd_n, bus.mcu_cs_n};
            sync_reg  <= meta_reg;
            rd_d_reg  <= rd_s;
            sec_d_reg <= sec_s;
        end
    end

    // Frame state machine transitions
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (bus.save_dat_to_fifo_flag) state_next = ST_WAIT_MCU;
            ST_WAIT_MCU: if (timeout_hit) state_next = ST_FLUSH;
                         else if (pop_data) state_next = ST_READING;
            ST_READING:  if (timeout_hit) state_next = ST_FLUSH;
                         else if (!words_left) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            ST_FLUSH:    if (bus.fifo_empty) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Read data mux for the register selected on the read event
    always_comb begin
        rdata_next = rdata_reg;
        if (read_evt) begin
            case (bus.mcu_addr)
                2'd0:    rdata_next = {frame_ready, underflow_reg, flushed_reg, bus.fifo_usedw};
                2'd1:    rdata_next = data_avail ? {last, 3'b000, bus.fifo_q} : 16'hFFFF;
                2'd2:    rdata_next = frame_cnt_reg;
                default: rdata_next = BLOCK_ID;
            endcase
        end
    end

    // State, counters, interrupt pulse, sticky flags and read data register
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            words_read_reg  <= '0;
            frame_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            irq_cnt_reg     <= '0;
            irq_reg         <= 1'b0;
            underflow_reg   <= 1'b0;
            flushed_reg     <= 1'b0;
            clr_pend_reg    <= 1'b0;
            rdata_reg       <= 16'h0000;
        end else begin
            state_reg <= state_next;
            rdata_reg <= rdata_next;

            if (state_reg == ST_IDLE)
                words_read_reg <= '0;
            else if (pop_data)
                words_read_reg <= words_read_reg + 13'd1;

            if (state_reg == ST_DONE)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;

            if (!in_frame || pop_data)
                timeout_cnt_reg <= '0;
            else if (sec_rise && (timeout_cnt_reg != TMO_LIMIT))
                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;

            // Pulse starts on WAIT_MCU entry; cut short if the frame closes
            if ((state_reg == ST_IDLE) && (state_next == ST_WAIT_MCU)) begin
                irq_reg     <= 1'b1;
                irq_cnt_reg <= IRQ_LOAD;
            end else if ((state_next != ST_WAIT_MCU) && (state_next != ST_READING)) begin
                irq_reg     <= 1'b0;
                irq_cnt_reg <= '0;
            end else if (irq_cnt_reg != '0) begin
                irq_cnt_reg <= irq_cnt_reg - 1'b1;
            end else begin
                irq_reg <= 1'b0;
            end

            // Status read clears the sticky bits on the cycle after the load;
            // a fresh set event in that cycle wins.
            clr_pend_reg <= read_evt && (bus.mcu_addr == 2'd0);
            if (data_rd && bus.fifo_empty)
                underflow_reg <= 1'b1;
            else if (clr_pend_reg)
                underflow_reg <= 1'b0;
            if ((state_reg == ST_FLUSH) && bus.fifo_empty)
                flushed_reg <= 1'b1;
            else if (clr_pend_reg)
                flushed_reg <= 1'b0;
        end
    end
endmodule
